// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: single-outstanding fetch FSM feeding a DEPTH-entry {pc, instr} FIFO.
// Optional macro PREFETCH_BYPASS_EN forwards a response straight to decode when the queue is empty.
module instr_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } state_e;

    state_e state_q;
    state_e state_d;

    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] count_q;
    logic [31:0]   fetch_pc_q;
    logic [31:0]   issued_pc_q;

    logic empty;
    logic req_go;
    logic resp_ok;
    logic bypass_hit;
    logic do_push;
    logic do_pop;

    assign empty   = (count_q == '0);
    assign req_go  = (state_q == IDLE) && (count_q != FULL)
                   && !redirect_i && !rst_i;
    assign resp_ok = (state_q == WAIT) && mem_valid_i && !redirect_i;
    assign do_pop  = !empty && ready_i && !redirect_i;

`ifdef PREFETCH_BYPASS_EN
    assign bypass_hit = resp_ok && empty;
    assign do_push    = resp_ok && !(bypass_hit && ready_i);
`else
    assign bypass_hit = 1'b0;
    assign do_push    = resp_ok;
`endif

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a redirect with a coincident response leaves nothing outstanding
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_go) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect_i) begin
                    state_d = mem_valid_i ? IDLE : DROP;
                end else if (mem_valid_i) begin
                    state_d = IDLE;
                end
            end
            DROP: begin
                if (mem_valid_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: fetch request and head-of-queue view for decode
    always_comb begin
        mem_req_o  = req_go;
        mem_addr_o = fetch_pc_q;
        valid_o    = (!empty || bypass_hit) && !rst_i;
        instr_o    = instr_mem[head_q];
        pc_o       = pc_mem[head_q];
        if (bypass_hit) begin
            instr_o = mem_data_i;
            pc_o    = issued_pc_q;
        end
    end

    // Fetch address, pointers and occupancy; redirect flushes everything
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_q  <= RESET_PC;
            issued_pc_q <= RESET_PC;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
        end else if (redirect_i) begin
            fetch_pc_q <= redirect_pc_i & 32'hFFFF_FFFC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            if (req_go) begin
                issued_pc_q <= fetch_pc_q;
                fetch_pc_q  <= fetch_pc_q + 32'd4;
            end
            if (do_push) begin
                tail_q <= tail_q + PW'(1);
            end
            if (do_pop) begin
                head_q <= head_q + PW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // Queue storage write at tail
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            pc_mem[tail_q]    <= issued_pc_q;
            instr_mem[tail_q] <= mem_data_i;
        end
    end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue: vector table plus hand-written fill/drain sequence.
// A second instance with RESET_PC=FFFF_FFF8 checks fetch address wraparound.
module tb_instr_prefetch_queue;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i = 1'b1;
    logic        mem_valid_i = 1'b0;
    logic [31:0] mem_data_i = '0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        ready_i = 1'b0;

    logic        mem_req_o, valid_o;
    logic [31:0] mem_addr_o, instr_o, pc_o;
    logic        w_req, w_valid;
    logic [31:0] w_addr, w_instr, w_pc;

    int n_cmp = 0;
    int n_err = 0;

    instr_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut (
        .clk_i(clk), .rst_i(rst_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_valid_i(mem_valid_i), .mem_data_i(mem_data_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .valid_o(valid_o), .ready_i(ready_i),
        .instr_o(instr_o), .pc_o(pc_o)
    );

    instr_prefetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk_i(clk), .rst_i(rst_i),
        .mem_req_o(w_req), .mem_addr_o(w_addr),
        .mem_valid_i(mem_valid_i), .mem_data_i(mem_data_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .valid_o(w_valid), .ready_i(ready_i),
        .instr_o(w_instr), .pc_o(w_pc)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

`ifdef PREFETCH_BYPASS_EN

    initial begin
        ready_i = 1'b1;
        @(negedge clk);
        #1;
        chk("rst.req", 32'(mem_req_o), 32'd0);
        chk("rst.valid", 32'(valid_o), 32'd0);
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        chk("byp.req", 32'(mem_req_o), 32'd1);
        chk("byp.addr", mem_addr_o, 32'h0);
        @(negedge clk);
        mem_valid_i = 1'b1;
        mem_data_i  = 32'h1234_5678;
        #1;
        chk("byp.valid", 32'(valid_o), 32'd1);
        chk("byp.instr", instr_o, 32'h1234_5678);
        chk("byp.pc", pc_o, 32'h0);
        @(negedge clk);
        mem_valid_i = 1'b0;
        #1;
        chk("byp.empty", 32'(valid_o), 32'd0);
        chk("byp.req2", 32'(mem_req_o), 32'd1);
        chk("byp.addr2", mem_addr_o, 32'h4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

`else

    typedef struct {
        logic        rst;
        logic        mv;
        logic [31:0] data;
        logic        rd;
        logic [31:0] rpc;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
        logic [31:0] ins;
        logic        wchk;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(
        logic rst, logic mv, logic [31:0] data, logic rd,
        logic [31:0] rpc, logic rdy, logic req, logic [31:0] addr,
        logic vld, logic [31:0] pc, logic [31:0] ins);
        vec_t r;
        r.rst = rst;  r.mv = mv;    r.data = data;
        r.rd = rd;    r.rpc = rpc;  r.rdy = rdy;
        r.req = req;  r.addr = addr;
        r.vld = vld;  r.pc = pc;    r.ins = ins;
        r.wchk = 1'b0;
        return r;
    endfunction

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return 32'hE000_0000 ^ a;
    endfunction

    initial begin
        logic        resp_due;
        logic [31:0] resp_addr;
        int          nreq;

        // rst mv data rd rpc rdy | req addr vld pc instr
        tbl.push_back(v(1,0,0,0,0,1, 0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,1, 1,32'h0,0,0,0));
        tbl.push_back(v(0,1,32'hA000_0000,0,0,1, 0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,1, 1,32'h4,1,32'h0,32'hA000_0000));
        tbl.push_back(v(0,1,32'hA000_0004,0,0,1, 0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,1, 1,32'h8,1,32'h4,32'hA000_0004));
        tbl.push_back(v(0,1,32'hA000_0008,0,0,1, 0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,1, 1,32'hC,1,32'h8,32'hA000_0008));
        tbl.push_back(v(1,0,0,0,0,1, 0,0,0,0,0));
        tbl.push_back(v(0,1,32'hDEAD_BEEF,0,0,0, 1,32'h0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0, 0,0,0,0,0));
        tbl.push_back(v(0,1,32'hB000_0000,0,0,0, 0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0, 1,32'h4,1,32'h0,32'hB000_0000));
        tbl.push_back(v(0,1,32'hB000_0004,0,0,0, 0,0,1,32'h0,32'hB000_0000));
        tbl.push_back(v(0,0,0,0,0,0, 1,32'h8,1,32'h0,32'hB000_0000));
        tbl.push_back(v(0,1,32'hB000_0008,0,0,0, 0,0,1,32'h0,32'hB000_0000));
        tbl.push_back(v(0,0,0,0,0,0, 1,32'hC,1,32'h0,32'hB000_0000));
        tbl.push_back(v(0,1,32'hB000_000C,0,0,0, 0,0,1,32'h0,32'hB000_0000));
        tbl.push_back(v(0,0,0,0,0,0, 0,0,1,32'h0,32'hB000_0000));
        tbl.push_back(v(0,1,32'hDEAD_0000,0,0,0, 0,0,1,32'h0,32'hB000_0000));
        tbl.push_back(v(0,0,0,0,0,1, 0,0,1,32'h0,32'hB000_0000));
        tbl.push_back(v(0,0,0,0,0,1, 1,32'h10,1,32'h4,32'hB000_0004));
        tbl.push_back(v(0,1,32'hB000_0010,0,0,1, 0,0,1,32'h8,32'hB000_0008));
        tbl.push_back(v(0,0,0,0,0,1, 1,32'h14,1,32'hC,32'hB000_000C));
        tbl.push_back(v(0,0,0,0,0,0, 0,0,1,32'h10,32'hB000_0010));
        tbl.push_back(v(0,0,0,1,32'h103,0, 0,0,1,32'h10,32'hB000_0010));
        tbl.push_back(v(0,0,0,0,0,0, 0,0,0,0,0));
        tbl.push_back(v(0,1,32'hDEAD_0014,0,0,0, 0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0, 1,32'h100,0,0,0));
        tbl.push_back(v(0,1,32'hC000_0100,0,0,0, 0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0, 1,32'h104,1,32'h100,32'hC000_0100));
        tbl.push_back(v(0,1,32'hDEAD_0104,1,32'h200,1, 0,0,1,32'h100,32'hC000_0100));
        tbl.push_back(v(0,0,0,0,0,1, 1,32'h200,0,0,0));
        tbl.push_back(v(0,1,32'hC000_0200,0,0,1, 0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,1, 1,32'h204,1,32'h200,32'hC000_0200));
        tbl.push_back(v(0,1,32'hC000_0204,0,0,1, 0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,1, 1,32'h208,1,32'h204,32'hC000_0204));
        tbl.push_back(v(0,0,0,1,32'h300,1, 0,0,0,0,0));
        tbl.push_back(v(0,1,32'hDEAD_0300,1,32'h400,1, 0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,1, 1,32'h400,0,0,0));
        tbl[1].wchk = 1'b1;
        tbl[3].wchk = 1'b1;
        tbl[5].wchk = 1'b1;

        // Table: drive before the edge, observe combinational outputs
        foreach (tbl[i]) begin
            @(negedge clk);
            rst_i         = tbl[i].rst;
            mem_valid_i   = tbl[i].mv;
            mem_data_i    = tbl[i].data;
            redirect_i    = tbl[i].rd;
            redirect_pc_i = tbl[i].rpc;
            ready_i       = tbl[i].rdy;
            #1;
            chk($sformatf("v%0d.req", i), 32'(mem_req_o), 32'(tbl[i].req));
            if (tbl[i].req) begin
                chk($sformatf("v%0d.addr", i), mem_addr_o, tbl[i].addr);
            end
            chk($sformatf("v%0d.valid", i), 32'(valid_o), 32'(tbl[i].vld));
            if (tbl[i].vld) begin
                chk($sformatf("v%0d.pc", i), pc_o, tbl[i].pc);
                chk($sformatf("v%0d.instr", i), instr_o, tbl[i].ins);
            end
            if (tbl[i].wchk) begin
                chk($sformatf("v%0d.wreq", i), 32'(w_req), 32'(tbl[i].req));
                chk($sformatf("v%0d.waddr", i), w_addr,
                    tbl[i].addr + 32'hFFFF_FFF8);
                chk($sformatf("v%0d.wvalid", i), 32'(w_valid), 32'(tbl[i].vld));
                if (tbl[i].vld) begin
                    chk($sformatf("v%0d.wpc", i), w_pc,
                        tbl[i].pc + 32'hFFFF_FFF8);
                    chk($sformatf("v%0d.winstr", i), w_instr, tbl[i].ins);
                end
            end
        end

        // Fill with ready low: 0x400 is outstanding, expect 4 requests total
        resp_due  = 1'b1;
        resp_addr = 32'h400;
        nreq      = 1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            redirect_i  = 1'b0;
            ready_i     = 1'b0;
            mem_valid_i = resp_due;
            mem_data_i  = mem_word(resp_addr);
            #1;
            resp_due = 1'b0;
            if (mem_req_o) begin
                chk($sformatf("fill.addr%0d", nreq), mem_addr_o,
                    32'h400 + 32'(4 * nreq));
                nreq++;
                resp_due  = 1'b1;
                resp_addr = mem_addr_o;
            end
        end
        chk("fill.nreq", 32'(nreq), 32'd4);

        // Drain in order; no further responses are supplied
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            mem_valid_i = 1'b0;
            ready_i     = 1'b1;
            #1;
            chk($sformatf("drain%0d.valid", k), 32'(valid_o), 32'd1);
            chk($sformatf("drain%0d.pc", k), pc_o, 32'h400 + 32'(4 * k));
            chk($sformatf("drain%0d.instr", k), instr_o,
                mem_word(32'h400 + 32'(4 * k)));
        end
        @(negedge clk);
        #1;
        chk("drain.empty", 32'(valid_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

`endif

endmodule
